// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the 4-bit ALU interface: buffers commands in a FIFO, issues
// them one at a time, waits out the ALU latency and returns the captured result.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_op,
  output logic       res_err,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a queued command; pops the FIFO head when one exists
  // ISSUE | operands on the ALU, counting down the ALU latency
  // RESP  | result presented on the result port until accepted
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, capture;
  logic [10:0]   head;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic [2:0]    pend_op;
  logic          pend_err, err_q;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pop          = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          wait_cnt_nxt = CW'(LATENCY);
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      pend_op  <= '0;
      pend_err <= 1'b0;
      res_data <= '0;
      res_op   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (pop) begin
        alu_a    <= head[10:7];
        alu_b    <= head[6:3];
        alu_op   <= head[2:0];
        pend_op  <= head[2:0];
        pend_err <= (head[2:0] == 3'b010) && (head[6:3] == 4'd0);
      end
      if (capture) begin
        res_data <= alu_result;
        res_op   <= pend_op;
        err_q    <= pend_err;
      end
    end
  end

  assign res_valid = (state == RESP);
  assign res_err   = err_q && res_valid;
  assign busy      = (state != IDLE) || !empty;

endmodule
